mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port synchronous memory between three requesters: the core's data port (Memory stage), its instruction-fetch port (Fetch stage), and the UART programmer's write port. It sits between the core bus signals and the physical memory. It grants one access at a time, returns read data, and drives `mem_hold` so the pipeline stalls while a core request is outstanding. The programmer has absolute priority while programming is enabled. Data and instruction requests alternate when they contend.

## Interface
Parameters:
- `ADDR_W`, 32, address width of every port
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `Rst`  in  1  asynchronous, active-high reset
- `prog_ena`  in  1  programming mode; core ports are never granted while it is high
- `d_req`  in  1  data request; held with stable attributes until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_be`  in  4  byte enables for writes (reads always return the full word)
- `d_addr`  in  ADDR_W  data address
- `d_din`  in  DATA_W  write data
- `d_dout`  out  DATA_W  read data, valid while `d_ack` = 1 and held afterwards
- `d_ack`  out  1  one-cycle completion pulse
- `i_req`, `i_addr`  in  1 / ADDR_W  instruction read request and address
- `i_dout`  out  DATA_W  instruction word, valid with `i_ack`
- `i_ack`  out  1  one-cycle completion pulse
- `p_req`, `p_addr`, `p_din`  in  1 / ADDR_W / DATA_W  programmer full-word write
- `p_ack`  out  1  one-cycle completion pulse
- `m_en`, `m_we`  out  1 / 1  memory enable and write strobe
- `m_be`  out  4  memory byte enables
- `m_addr`, `m_din`  out  ADDR_W / DATA_W  memory address and write data
- `m_dout`  in  DATA_W  memory read data, valid the cycle after `m_en`
- `mem_hold`  out  1  pipeline stall request

## Operation
- FSM has two states, IDLE and WAIT, plus an `owner` register (D / I / P) and a `last` flag (last core grant was D or I).
- **IDLE:** select a winner from the eligible requests.
  - A port is ineligible in the cycle its ack is high.
  - If `prog_ena` = 1, only P is eligible.
  - If `prog_ena` = 0: P is ineligible. If D and I are both eligible, the winner is the port opposite to `last`. Otherwise the single requester wins.
  - Drive `m_*` combinationally from the winner, record it in `owner`, update `last` on a core grant, then go to WAIT.
  - With no winner: `m_en` = 0 and the FSM stays in IDLE.
- **WAIT:**
  - `m_en` = 0.
  - If `owner` is D-read or I, capture `m_dout` into `d_dout` or `i_dout`.
  - Set the owner's ack register for the next cycle, then return to IDLE.
- Write byte enables:
  - D write: `m_be` = `d_be`.
  - P write: `m_be` = 4'hF.
  - Any read: `m_be` = 4'hF with `m_we` = 0.
- `mem_hold` = (`d_req` & ~`d_ack`) | (`i_req` & ~`i_ack`), forced to 0 while `Rst` is high.
- A request withdrawn before grant is never issued. A granted access always completes and its ack is pulsed even if the request has dropped.
- `prog_ena` falling or rising during WAIT does not abort the access in flight.

## Timing
- Reset values:
  - state = IDLE, `owner` = D, `last` = I (so D wins first contention)
  - all acks 0, `d_dout` = `i_dout` = 0
  - `m_en` = `m_we` = 0, `m_be` = 0, `m_addr` = `m_din` = 0
- Asynchronous reset mid-access: the access is abandoned, no ack is ever issued for it, and memory outputs drop to 0 immediately.
- Latency: request first seen in IDLE at cycle N gives `m_en` at N, data captured at the end of N+1, and ack (with data) at N+2.
- Throughput: one access per 2 cycles. A new grant may issue in the same cycle as the previous ack, to a different port only.
- Contention: two persistent D and I requests alternate D, I, D, … with grants spaced 2 cycles apart.
- `mem_hold` is combinational from its inputs, so it is already high in the cycle a core request first rises.

## Test plan
- **D read:** `d_req`, `d_addr` = 0x10, memory word 0xDEADBEEF → `m_en` at N, `d_ack` = 1 with `d_dout` = 0xDEADBEEF at N+2, `mem_hold` high during N..N+1.
- **Contention:** `d_req` and `i_req` rise together, both held → grant order D, I, D, I; `m_en` in cycles 0, 2, 4, 6; acks in cycles 2, 4, 6, 8.
- **Programming:** `prog_ena` = 1, `p_req` write 0x12345678 to 0x40 while `i_req` is pending → `m_we` = 1, `m_be` = 4'hF, `p_ack` at N+2, no I grant. After `prog_ena` falls, an I read of 0x40 returns 0x12345678.
- **Byte write:** D write `d_be` = 4'b0010, `d_din` = 0x0000AB00 to a word holding 0x11223344 → subsequent read returns 0x1122AB44.
- **Reset in WAIT:** assert `Rst` in the WAIT cycle → no ack is ever produced, all outputs 0. After release, a fresh request completes normally in 2 cycles.
- **Dropped request:** `d_req` pulses for 1 cycle while I is in WAIT → no D grant, no `d_ack`.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way arbiter sharing one single-port synchronous memory between the core
// data port, the instruction-fetch port and the UART programmer.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic                prog_ena,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_din,
  output logic [DATA_W-1:0]   d_dout,
  output logic                d_ack,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_dout,
  output logic                i_ack,
  input  logic                p_req,
  input  logic [ADDR_W-1:0]   p_addr,
  input  logic [DATA_W-1:0]   p_din,
  output logic                p_ack,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_din,
  input  logic [DATA_W-1:0]   m_dout,
  output logic                mem_hold
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_D, OWN_I, OWN_P} owner_t;

  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic   owner_rd, owner_rd_nxt;  // data-port access in flight is a read
  logic   last_i, last_i_nxt;      // most recent core grant went to fetch

  logic d_elig, i_elig, p_elig;
  logic grant_d, grant_i, grant_p;

  // Programming mode hands the memory exclusively to the programmer; a port
  // whose ack is high is completing and must not be re-granted this cycle.
  always_comb begin
    d_elig  = d_req & ~d_ack & ~prog_ena;
    i_elig  = i_req & ~i_ack & ~prog_ena;
    p_elig  = p_req & ~p_ack & prog_ena;
    grant_d = 1'b0;
    grant_i = 1'b0;
    grant_p = 1'b0;
    if (p_elig) begin
      grant_p = 1'b1;
    end else if (d_elig && i_elig) begin
      if (last_i) grant_d = 1'b1;
      else        grant_i = 1'b1;
    end else if (d_elig) begin
      grant_d = 1'b1;
    end else if (i_elig) begin
      grant_i = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_nxt    = state;
    owner_nxt    = owner;
    owner_rd_nxt = owner_rd;
    last_i_nxt   = last_i;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_be         = '0;
    m_addr       = '0;
    m_din        = '0;
    case (state)
      S_IDLE: begin
        if (grant_d) begin
          m_en         = 1'b1;
          m_we         = d_we;
          m_be         = d_we ? d_be : '1;
          m_addr       = d_addr;
          m_din        = d_din;
          owner_nxt    = OWN_D;
          owner_rd_nxt = ~d_we;
          last_i_nxt   = 1'b0;
          state_nxt    = S_WAIT;
        end else if (grant_i) begin
          m_en         = 1'b1;
          m_be         = '1;
          m_addr       = i_addr;
          owner_nxt    = OWN_I;
          owner_rd_nxt = 1'b1;
          last_i_nxt   = 1'b1;
          state_nxt    = S_WAIT;
        end else if (grant_p) begin
          m_en         = 1'b1;
          m_we         = 1'b1;
          m_be         = '1;
          m_addr       = p_addr;
          m_din        = p_din;
          owner_nxt    = OWN_P;
          owner_rd_nxt = 1'b0;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // The memory port is driven combinationally, so reset must silence it
    // directly rather than wait for the state register.
    if (Rst) begin
      m_en   = 1'b0;
      m_we   = 1'b0;
      m_be   = '0;
      m_addr = '0;
      m_din  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      owner    <= OWN_D;
      owner_rd <= 1'b0;
      last_i   <= 1'b1;
      d_ack    <= 1'b0;
      i_ack    <= 1'b0;
      p_ack    <= 1'b0;
      d_dout   <= '0;
      i_dout   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      owner_rd <= owner_rd_nxt;
      last_i   <= last_i_nxt;
      d_ack    <= (state == S_WAIT) && (owner == OWN_D);
      i_ack    <= (state == S_WAIT) && (owner == OWN_I);
      p_ack    <= (state == S_WAIT) && (owner == OWN_P);
      if ((state == S_WAIT) && (owner == OWN_D) && owner_rd) d_dout <= m_dout;
      if ((state == S_WAIT) && (owner == OWN_I))             i_dout <= m_dout;
    end
  end

  assign mem_hold = ~Rst & ((d_req & ~d_ack) | (i_req & ~i_ack));

endmodule
